linebuff_mem: RTL and testbench

LINEBUFF_MEM -- requirements
Module: linebuff_mem

---
 rtl/linebuff_pkg.sv | 20 ++
 rtl/linebuff_ram.sv | 43 ++++
 rtl/linebuff_mem.sv | 135 +++++++++++++
 tb/tb_linebuff_mem.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/linebuff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | linebuff_pkg                                                         |
// | Shared state encoding and word-width helper for the line buffer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package linebuff_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } lb_state_e;

  // One stored word carries every tap except the live one.
  function automatic int word_width(input int taps, input int dw);
    return (taps - 1) * dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/linebuff_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | linebuff_ram                                                         |
// | Simple dual-port line store: one write port, one registered read.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module linebuff_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Separate process from the write: a same-address collision reads the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/linebuff_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | linebuff_mem                                                         |
// | Line buffer with power-up clear sweep, range checking and a sticky   |
// | out-of-range flag. Define LINEBUFF_BYPASS_EN for write-first         |
// | collision behaviour (read-first otherwise).                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module linebuff_mem
  import linebuff_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int TAP_NUMS   = 3,
  parameter int DEPTH      = 2048
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          ce_i,
  input  logic                                          rd_en_i,
  input  logic [ADDR_WIDTH-1:0]                         rd_addr_i,
  output logic [word_width(TAP_NUMS, DATA_WIDTH)-1:0]   rd_data_o,
  output logic                                          rd_valid_o,
  input  logic                                          wr_en_i,
  input  logic [ADDR_WIDTH-1:0]                         wr_addr_i,
  input  logic [word_width(TAP_NUMS, DATA_WIDTH)-1:0]   wr_data_i,
  output logic                                          busy_o,
  output logic                                          err_oor_o,
  input  logic                                          clr_err_i
);

  localparam int c_word_w = word_width(TAP_NUMS, DATA_WIDTH);
  localparam int c_aw     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lb_state_e             r_state;
  logic [c_aw-1:0]       r_init_ptr;
  logic                  r_rd_valid;
  logic                  r_err_oor;

  logic                  w_ready;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic                  w_rd_fire;
  logic                  w_wr_fire;
  logic                  w_oor_set;
  logic                  w_ram_we;
  logic [c_aw-1:0]       w_ram_waddr;
  logic [c_word_w-1:0]   w_ram_wdata;
  logic [c_word_w-1:0]   w_ram_q;

  assign w_ready   = (r_state == READY);
  // Full-width compare so aliased high addresses are rejected, not wrapped.
  assign w_rd_ok   = (rd_addr_i < ADDR_WIDTH'(DEPTH));
  assign w_wr_ok   = (wr_addr_i < ADDR_WIDTH'(DEPTH));
  assign w_rd_fire = ce_i & w_ready & rd_en_i & w_rd_ok;
  assign w_wr_fire = ce_i & w_ready & wr_en_i & w_wr_ok;
  assign w_oor_set = ce_i & w_ready & ((rd_en_i & ~w_rd_ok) | (wr_en_i & ~w_wr_ok));

  assign w_ram_we    = (ce_i & ~w_ready) | w_wr_fire;
  assign w_ram_waddr = w_ready ? wr_addr_i[c_aw-1:0] : r_init_ptr;
  assign w_ram_wdata = w_ready ? wr_data_i : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= INIT;
      r_init_ptr <= '0;
    end else if (ce_i && (r_state == INIT)) begin
      if (r_init_ptr == c_aw'(DEPTH - 1)) begin
        r_state    <= READY;
        r_init_ptr <= '0;
      end else begin
        r_init_ptr <= r_init_ptr + c_aw'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
    end else if (ce_i) begin
      r_rd_valid <= w_rd_fire;
    end
  end

  // A new violation outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_oor <= 1'b0;
    end else if (w_oor_set) begin
      r_err_oor <= 1'b1;
    end else if (clr_err_i) begin
      r_err_oor <= 1'b0;
    end
  end

  linebuff_ram #(
    .WIDTH (c_word_w),
    .DEPTH (DEPTH),
    .AW    (c_aw)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_ram_we),
    .i_wr_addr (w_ram_waddr),
    .i_wr_data (w_ram_wdata),
    .i_rd_en   (w_rd_fire),
    .i_rd_addr (rd_addr_i[c_aw-1:0]),
    .o_rd_data (w_ram_q)
  );

`ifdef LINEBUFF_BYPASS_EN
  logic                r_byp_sel;
  logic [c_word_w-1:0] r_byp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp_sel  <= 1'b0;
      r_byp_data <= '0;
    end else if (w_rd_fire) begin
      r_byp_sel  <= w_wr_fire & (wr_addr_i == rd_addr_i);
      r_byp_data <= wr_data_i;
    end
  end

  assign rd_data_o = r_byp_sel ? r_byp_data : w_ram_q;
`else
  assign rd_data_o = w_ram_q;
`endif

  assign rd_valid_o = r_rd_valid;
  assign err_oor_o  = r_err_oor;
  assign busy_o     = ~w_ready;

endmodule
`default_nettype wire

// File: tb/tb_linebuff_mem.sv
`default_nettype none
// Self-checking bench for linebuff_mem: directed table, corner sequences
// and randomized traffic against a behavioural reference model.
module tb_linebuff_mem;

  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int TAPS  = 3;
  localparam int DEPTH = 16;
  localparam int W     = 16;

`ifdef LINEBUFF_BYPASS_EN
  localparam bit             BYPASS = 1'b1;
  localparam logic [W-1:0]   COLL   = 16'h1234;
`else
  localparam bit             BYPASS = 1'b0;
  localparam logic [W-1:0]   COLL   = 16'hBEEF;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic          clr = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0] m_mem [DEPTH];
  int           m_init_cnt;
  logic [W-1:0] m_rd_data;
  logic         m_rd_valid;
  logic         m_err;

  typedef struct {
    bit          ce;
    bit          rd;
    logic [31:0] ra;
    bit          wr;
    logic [31:0] wa;
    logic [15:0] wd;
    bit          clr;
    bit          ev;
    logic [15:0] ed;
    bit          ee;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  linebuff_mem #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TAP_NUMS   (TAPS),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce_i       (ce),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .busy_o     (busy),
    .err_oor_o  (err),
    .clr_err_i  (clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_busy"},  {31'd0, busy},     {31'd0, (m_init_cnt < DEPTH)});
    check({tag, "_valid"}, {31'd0, rd_valid}, {31'd0, m_rd_valid});
    check({tag, "_data"},  {16'd0, rd_data},  {16'd0, m_rd_data});
    check({tag, "_err"},   {31'd0, err},      {31'd0, m_err});
  endtask

  // Behavioural rules: a sweep of DEPTH enabled cycles clears the store,
  // then reads/writes in range act, out-of-range ones only raise the flag.
  task automatic model_step(input bit c, input bit r, input logic [31:0] ra,
                            input bit w, input logic [31:0] wa, input logic [15:0] wd,
                            input bit cl);
    bit set;
    set = 1'b0;
    if (c) begin
      if (m_init_cnt < DEPTH) begin
        m_mem[m_init_cnt] = '0;
        m_init_cnt++;
        m_rd_valid = 1'b0;
      end else begin
        set = (r && ra >= DEPTH) || (w && wa >= DEPTH);
        if (r && ra < DEPTH) begin
          m_rd_data  = (BYPASS && w && wa == ra) ? wd : m_mem[ra];
          m_rd_valid = 1'b1;
        end else begin
          m_rd_valid = 1'b0;
        end
        if (w && wa < DEPTH) m_mem[wa] = wd;
      end
    end
    if (set) m_err = 1'b1;
    else if (cl) m_err = 1'b0;
  endtask

  task automatic model_reset();
    m_init_cnt = 0;
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_err      = 1'b0;
  endtask

  task automatic do_cycle(input bit c, input bit r, input logic [31:0] ra,
                          input bit w, input logic [31:0] wa, input logic [15:0] wd,
                          input bit cl);
    ce = c; rd_en = r; rd_addr = ra; wr_en = w; wr_addr = wa; wr_data = wd; clr = cl;
    @(posedge clk);
    model_step(c, r, ra, w, wa, wd, cl);
    #1;
    check_outputs("cyc");
  endtask

  // Called 1 time unit after an active edge; checks the asynchronous effect.
  task automatic assert_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs(tag);
  endtask

  task automatic release_reset(input int n);
    ce = 1'b1; rd_en = 1'b1; wr_en = 1'b1; rd_addr = 32'd3; wr_addr = 32'd3; clr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check_outputs("in_rst");
    rst_n = 1'b1;
  endtask

  task automatic init_sweep(input string tag);
    check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    for (int k = 1; k <= DEPTH; k++) begin
      // Traffic during the sweep, including out-of-range, must be ignored.
      do_cycle(1'b1, 1'b1, (k % 2 == 0) ? 32'd40 : 32'd2, 1'b1, (k % 3 == 0) ? 32'd99 : 32'd2,
               16'hFFFF, 1'b0);
      check({tag, "_busy"},  {31'd0, busy},     (k < DEPTH) ? 32'd1 : 32'd0);
      check({tag, "_valid"}, {31'd0, rd_valid}, 32'd0);
      check({tag, "_err"},   {31'd0, err},      32'd0);
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      do_cycle(1'b1, 1'b1, a, 1'b0, 32'd0, 16'd0, 1'b0);
      check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
      check({tag, "_data"},  {16'd0, rd_data},  32'd0);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h8000_0000 | $urandom_range(0, 15);
      1:       return $urandom_range(16, 40);
      default: return $urandom_range(0, 15);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    check_outputs("por");
    release_reset(3);
    init_sweep("sweep1");
    read_all_zero("rdzero1");

    //        ce    rd    ra               wr    wa               wd        clr   ev    ed        ee
    tbl.push_back('{1'b1, 1'b0, 32'd0,          1'b1, 32'd5,          16'hA55A, 1'b0, 1'b0, 16'h0000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'd5,          1'b0, 32'd0,          16'h0000, 1'b0, 1'b1, 16'hA55A, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'd5,          1'b1, 32'd7,          16'hBEEF, 1'b0, 1'b1, 16'hA55A, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'd7,          1'b1, 32'd7,          16'h1234, 1'b0, 1'b1, COLL,     1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'd7,          1'b0, 32'd0,          16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'd0,          1'b1, 32'd20,         16'hFFFF, 1'b0, 1'b0, 16'h1234, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 32'd16,         1'b0, 32'd0,          16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 32'd0,          1'b0, 32'd0,          16'h0000, 1'b1, 1'b0, 16'h1234, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'd4,          1'b0, 32'd0,          16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'd0,          1'b1, 32'h0000_0105,  16'hDEAD, 1'b0, 1'b0, 16'h0000, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 32'h8000_0005,  1'b0, 32'd0,          16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 32'd5,          1'b0, 32'd0,          16'h0000, 1'b1, 1'b1, 16'hA55A, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'd9,          1'b1, 32'd3,          16'h1111, 1'b0, 1'b1, 16'h0000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'd3,          1'b0, 32'd0,          16'h0000, 1'b0, 1'b1, 16'h1111, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      do_cycle(tbl[i].ce, tbl[i].rd, tbl[i].ra, tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].clr);
      check($sformatf("tbl%0d_valid", i), {31'd0, rd_valid}, {31'd0, tbl[i].ev});
      check($sformatf("tbl%0d_data", i),  {16'd0, rd_data},  {16'd0, tbl[i].ed});
      check($sformatf("tbl%0d_err", i),   {31'd0, err},      {31'd0, tbl[i].ee});
    end

    // Clock-enable freeze: outputs hold and the gated write is discarded.
    do_cycle(1'b1, 1'b1, 32'd5, 1'b0, 32'd0, 16'h0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      do_cycle(1'b0, 1'b1, 32'd7, 1'b1, 32'd7, 16'hFFFF, 1'b0);
      check("frz_valid", {31'd0, rd_valid}, 32'd1);
      check("frz_data",  {16'd0, rd_data},  32'h0000_A55A);
      check("frz_busy",  {31'd0, busy},     32'd0);
    end
    do_cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 16'h0000, 1'b0);
    check("resume_valid", {31'd0, rd_valid}, 32'd0);
    check("resume_data",  {16'd0, rd_data},  32'h0000_A55A);
    do_cycle(1'b1, 1'b1, 32'd7, 1'b0, 32'd0, 16'h0000, 1'b0);
    check("resume_rd7",   {16'd0, rd_data},  32'h0000_1234);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra;
      logic [31:0] wa;
      ra = pick_addr();
      wa = ($urandom_range(0, 3) == 0) ? ra : pick_addr();
      do_cycle($urandom_range(0, 5) != 0, $urandom_range(0, 2) != 0, ra,
               $urandom_range(0, 1) == 1, wa, 16'($urandom), $urandom_range(0, 7) == 0);
    end

    // Reset in the middle of a valid read with the error flag raised.
    do_cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'd2, 16'hCAFE, 1'b1);
    do_cycle(1'b1, 1'b1, 32'd2, 1'b1, 32'd30, 16'h0000, 1'b0);
    check("pre_rst_valid", {31'd0, rd_valid}, 32'd1);
    check("pre_rst_data",  {16'd0, rd_data},  32'h0000_CAFE);
    check("pre_rst_err",   {31'd0, err},      32'd1);
    assert_reset("midacc_rst");
    check("midacc_data", {16'd0, rd_data}, 32'd0);
    check("midacc_err",  {31'd0, err},     32'd0);
    release_reset(2);

    // Reset again once the sweep pointer reaches 8.
    for (int k = 0; k < 8; k++) begin
      do_cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 16'h0000, 1'b0);
    end
    assert_reset("midinit_rst");
    check("midinit_busy",  {31'd0, busy},     32'd1);
    check("midinit_valid", {31'd0, rd_valid}, 32'd0);
    release_reset(2);
    init_sweep("sweep2");
    read_all_zero("rdzero2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
